// File: rtl/nios_accelerometer_fir_out_sched.sv
// rtl/nios_accelerometer_fir_out_sched.sv - round-robin scheduler from FIR channels to per-axis PIO writes
module nios_accelerometer_fir_out_sched #(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 31,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clr_overrun,
  input  logic [NUM_CH-1:0]        smp_strobe,
  input  logic [NUM_CH*DATA_W-1:0] smp_data,
  output logic [NUM_CH-1:0]        pio_chipselect,
  output logic [1:0]               pio_address,
  output logic                     pio_write_n,
  output logic [31:0]              pio_writedata,
  output logic [NUM_CH-1:0]        pending,
  output logic [NUM_CH*8-1:0]      overrun_cnt,
  output logic                     busy
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t                          r_state;
  logic [CW-1:0]                   r_grant;
  logic [CW-1:0]                   r_last_grant;
  logic [3:0]                      r_gap_cnt;
  logic [NUM_CH-1:0]               r_cs;
  logic                            r_write_n;
  logic [31:0]                     r_writedata;
  logic [NUM_CH-1:0]               r_pending;
  logic [NUM_CH-1:0][DATA_W-1:0]   r_hold;
  logic [NUM_CH-1:0][7:0]          r_ovr;

  logic [CW-1:0]                   w_grant;
  logic                            w_any;
  logic [NUM_CH-1:0]               w_issue_clr;
  logic [NUM_CH-1:0]               w_ovr;
  logic [NUM_CH-1:0]               w_onehot0;

  assign w_onehot0 = {{(NUM_CH-1){1'b0}}, 1'b1};

  // First pending channel searching upward from the one after the last grant.
  always_comb begin
    logic [CW-1:0] idx;
    w_any   = 1'b0;
    w_grant = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(r_last_grant) + k) % NUM_CH);
      if (!w_any && r_pending[idx]) begin
        w_any   = 1'b1;
        w_grant = idx;
      end
    end
  end

  assign w_issue_clr = (r_state == S_ISSUE) ? (w_onehot0 << r_grant) : '0;
  assign w_ovr       = smp_strobe & r_pending & ~w_issue_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_hold    <= '0;
      r_ovr     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (smp_strobe[i]) r_hold[i] <= smp_data[i*DATA_W +: DATA_W];
        r_pending[i] <= smp_strobe[i] | (r_pending[i] & ~w_issue_clr[i]);
        if (clr_overrun) r_ovr[i] <= w_ovr[i] ? 8'd1 : 8'd0;
        else if (w_ovr[i] && (r_ovr[i] != 8'hFF)) r_ovr[i] <= r_ovr[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= CW'(NUM_CH - 1);
      r_gap_cnt    <= '0;
      r_cs         <= '0;
      r_write_n    <= 1'b1;
      r_writedata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && w_any) begin
            r_state     <= S_ISSUE;
            r_grant     <= w_grant;
            r_cs        <= w_onehot0 << w_grant;
            r_write_n   <= 1'b0;
            r_writedata <= 32'(r_hold[w_grant]);
          end
        end
        S_ISSUE: begin
          r_cs         <= '0;
          r_write_n    <= 1'b1;
          r_last_grant <= r_grant;
          if (GAP_CYCLES > 0) begin
            r_state   <= S_GAP;
            r_gap_cnt <= 4'(GAP_CYCLES - 1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 4'd0) r_state <= S_IDLE;
          else r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pio_chipselect = r_cs;
  assign pio_address    = 2'b00;
  assign pio_write_n    = r_write_n;
  assign pio_writedata  = r_writedata;
  assign pending        = r_pending;
  assign overrun_cnt    = r_ovr;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_nios_accelerometer_fir_out_sched.sv
// tb/tb_nios_accelerometer_fir_out_sched.sv - directed self-checking bench for the PIO write scheduler
module tb_nios_accelerometer_fir_out_sched;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 31;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     enable;
  logic                     clr_overrun;
  logic [NUM_CH-1:0]        smp_strobe;
  logic [NUM_CH*DATA_W-1:0] smp_data;
  logic [NUM_CH-1:0]        pio_chipselect;
  logic [1:0]               pio_address;
  logic                     pio_write_n;
  logic [31:0]              pio_writedata;
  logic [NUM_CH-1:0]        pending;
  logic [NUM_CH*8-1:0]      overrun_cnt;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  nios_accelerometer_fir_out_sched #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .GAP_CYCLES(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .clr_overrun    (clr_overrun),
    .smp_strobe     (smp_strobe),
    .smp_data       (smp_data),
    .pio_chipselect (pio_chipselect),
    .pio_address    (pio_address),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pending        (pending),
    .overrun_cnt    (overrun_cnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [DATA_W-1:0] val);
    smp_data[ch*DATA_W +: DATA_W] = val;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic chk_write(input string tag, input logic [2:0] cs, input logic [31:0] wd);
    chk({tag, "_cs"}, 64'(pio_chipselect), 64'(cs));
    chk({tag, "_wn"}, 64'(pio_write_n), 64'd0);
    chk({tag, "_wd"}, 64'(pio_writedata), 64'(wd));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cs0"}, 64'(pio_chipselect), 64'd0);
    chk({tag, "_wn1"}, 64'(pio_write_n), 64'd1);
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b1;
    clr_overrun = 1'b0;
    smp_strobe  = '0;
    smp_data    = '0;
    do_reset();

    // reset values
    chk("rst_cs", 64'(pio_chipselect), 64'd0);
    chk("rst_wn", 64'(pio_write_n), 64'd1);
    chk("rst_addr", 64'(pio_address), 64'd0);
    chk("rst_wd", 64'(pio_writedata), 64'd0);
    chk("rst_pend", 64'(pending), 64'd0);
    chk("rst_ovr", 64'(overrun_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // single strobe on ch1
    set_data(1, 31'h12345678);
    smp_strobe = 3'b010;
    step();
    smp_strobe = '0;
    chk("t1_pend", 64'(pending), 64'b010);
    chk("t1_busy0", 64'(busy), 64'd0);
    step();
    chk_write("t1_wr", 3'b010, 32'h12345678);
    chk("t1_busy1", 64'(busy), 64'd1);
    chk("t1_addr", 64'(pio_address), 64'd0);
    step();
    chk_quiet("t1_gap");
    chk("t1_busy2", 64'(busy), 64'd1);
    chk("t1_pend0", 64'(pending), 64'd0);
    step();
    chk("t1_idle", 64'(busy), 64'd0);

    // three simultaneous strobes from a fresh reset
    do_reset();
    set_data(0, 31'h11);
    set_data(1, 31'h22);
    set_data(2, 31'h33);
    smp_strobe = 3'b111;
    step();
    smp_strobe = '0;
    chk("t2_pend", 64'(pending), 64'b111);
    step();
    chk_write("t2_w0", 3'b001, 32'h11);
    step();
    chk_quiet("t2_gap0");
    step();
    chk_quiet("t2_idle0");
    step();
    chk_write("t2_w1", 3'b010, 32'h22);
    step();
    step();
    step();
    chk_write("t2_w2", 3'b100, 32'h33);
    step();
    chk("t2_pend0", 64'(pending), 64'd0);
    step();
    chk("t2_busy0", 64'(busy), 64'd0);

    // overrun on ch0 while enable is low; latest sample wins
    enable = 1'b0;
    set_data(0, 31'hA);
    smp_strobe = 3'b001;
    step();
    set_data(0, 31'hB);
    step();
    smp_strobe = '0;
    chk("t3_ovr0", 64'(overrun_cnt[7:0]), 64'd1);
    chk("t3_pend", 64'(pending), 64'b001);
    step();
    step();
    chk("t3_hold_busy", 64'(busy), 64'd0);
    chk_quiet("t3_hold");
    enable = 1'b1;
    step();
    chk_write("t3_wr", 3'b001, 32'hB);
    step();
    step();
    chk("t3_pend0", 64'(pending), 64'd0);

    // strobe on ch2 during its own ISSUE cycle
    set_data(2, 31'hD);
    smp_strobe = 3'b100;
    step();
    smp_strobe = '0;
    step();
    chk_write("t4_wD", 3'b100, 32'hD);
    set_data(2, 31'hC);
    smp_strobe = 3'b100;
    step();
    smp_strobe = '0;
    chk("t4_pend_kept", 64'(pending), 64'b100);
    chk("t4_ovr2", 64'(overrun_cnt[23:16]), 64'd0);
    step();
    step();
    chk_write("t4_wC", 3'b100, 32'hC);
    step();
    step();
    chk("t4_pend0", 64'(pending), 64'd0);

    // overrun saturation and clear/overrun collision
    enable = 1'b0;
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("t5_clr", 64'(overrun_cnt), 64'd0);
    for (int i = 0; i < 300; i++) begin
      set_data(0, 31'(i));
      smp_strobe = 3'b001;
      step();
      if (i == 9) chk("t5_ovr9", 64'(overrun_cnt[7:0]), 64'd9);
    end
    chk("t5_sat", 64'(overrun_cnt[7:0]), 64'd255);
    set_data(0, 31'h55);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    smp_strobe = '0;
    chk("t5_clr_ovr", 64'(overrun_cnt), 64'h000001);
    enable = 1'b1;
    step();
    chk_write("t5_wr", 3'b001, 32'h55);
    step();
    step();

    // asynchronous reset during ISSUE, then ch0 before ch1
    set_data(1, 31'h77);
    smp_strobe = 3'b010;
    step();
    smp_strobe = '0;
    step();
    chk_write("t6_pre", 3'b010, 32'h77);
    reset_n = 1'b0;
    #1;
    chk_quiet("t6_async");
    chk("t6_pend", 64'(pending), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    step();
    reset_n = 1'b1;
    set_data(0, 31'h100);
    set_data(1, 31'h200);
    smp_strobe = 3'b011;
    step();
    smp_strobe = '0;
    step();
    chk_write("t6_w0", 3'b001, 32'h100);
    step();
    step();
    step();
    chk_write("t6_w1", 3'b010, 32'h200);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
